alu_result_buffer: RTL

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_result_buffer_if.sv | 25 ++
 rtl/alu_result_buffer.sv | 98 +++++++++
 2 files changed

// File: rtl/alu_result_buffer_if.sv
// Handshake bus between the 4-bit adder, the result buffer and its consumer.
// master drives results in and takes them out; slave is the buffer itself.
interface alu_result_buffer_if;
    logic [3:0] SUM;
    logic       OVERFLOW;
    logic       IN_VALID;
    logic       IN_READY;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [3:0] OUT_DATA;
    logic       OUT_CARRY;
    logic       OUT_ZERO;

    // Valid/ready: a transfer happens on a rising clock edge where both are high;
    // ready never depends combinationally on valid in either direction.
    modport master (
        output SUM, OVERFLOW, IN_VALID, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_CARRY, OUT_ZERO
    );

    modport slave (
        input  SUM, OVERFLOW, IN_VALID, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_CARRY, OUT_ZERO
    );
endinterface

// File: rtl/alu_result_buffer.sv
// Small FIFO of adder results {carry,sum} with head flags and overflow statistics.
// Head outputs come straight from storage, so a written entry appears one cycle later.
module alu_result_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    alu_result_buffer_if.slave       bus,
    input  logic                     CLEAR_FLAGS,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     STICKY_OVF,
    output logic [7:0]               OVF_COUNT
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [4:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          sticky_q, sticky_d;
    logic [7:0]    count_q, count_d;

    logic          empty;
    logic          full;
    logic          wr_en;
    logic          rd_en;
    logic [4:0]    head;

    assign empty = (level_q == '0);
    assign full  = (level_q == FULL_LEVEL);
    // Nothing moves while reset is held, even if the handshake looks complete.
    assign wr_en = bus.IN_VALID && !full && !RESET;
    assign rd_en = bus.OUT_READY && !empty && !RESET;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        sticky_d = sticky_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        // A clear wins over an overflow accepted in the same cycle.
        if (CLEAR_FLAGS) begin
            sticky_d = 1'b0;
            count_d  = 8'd0;
        end else if (wr_en && bus.OVERFLOW) begin
            sticky_d = 1'b1;
            if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sticky_q <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: its contents are masked whenever the buffer is empty.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {bus.OVERFLOW, bus.SUM};
        end
    end

    assign bus.IN_READY  = !full;
    assign bus.OUT_VALID = !empty;
    assign bus.OUT_DATA  = empty ? 4'd0 : head[3:0];
    assign bus.OUT_CARRY = empty ? 1'b0 : head[4];
    assign bus.OUT_ZERO  = !empty && (head[3:0] == 4'd0);

    assign LEVEL      = level_q;
    assign STICKY_OVF = sticky_q;
    assign OVF_COUNT  = count_q;
endmodule
